spi_miso_rx: RTL and testbench
==============================

# spi_miso_rx

Master-side SPI receive engine for SPI mode 0. Generates `sclk` and `cs_n` from the system clock, shifts in `miso` MSB-first, and hands each completed byte to the output FIFO stage on a `wvalid`/`wready` handshake. A frame is a fixed `FRAME_BYTES` bytes, matching the 120-bit frame buffer downstream. Sits directly upstream of the output FIFO and drives its `wdata`.

## Interface
- `DSIZE`, 8: bits per word; shifted MSB-first.
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles. Minimum 1, or 3 when `SPI_MISO_SYNC_EN` is defined.
- `FRAME_BYTES`, 15: words per frame.
- `clk`  in  1: single system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: frame request; sampled only in IDLE.
- `miso`  in  1: serial data from the slave.
- `wready`  in  1: downstream can accept a word.
- `sclk`  out  1: SPI clock, idle low.
- `cs_n`  out  1: chip select, active low.
- `wdata`  out  DSIZE: received word; holds its value until the next word.
- `wvalid`  out  1: one-cycle pulse per word.
- `frame_done`  out  1: one-cycle pulse, coincident with the last `wvalid` of a frame.
- `busy`  out  1: high from the cycle after `start` is accepted until return to IDLE.
- `byte_cnt`  out  $clog2(FRAME_BYTES+1): number of words delivered in the current frame.

## Operation
- Reset values: IDLE, `sclk`=0, `cs_n`=1, `wdata`=0, `wvalid`=0, `frame_done`=0, `busy`=0, `byte_cnt`=0. Bit counter and divider counter are 0.
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP.
- IDLE + `start`=1 → SETUP. `cs_n`=0 and `busy`=1 from the next edge. `byte_cnt` clears. `start` in any other state is ignored.
- SETUP lasts CLK_DIV cycles with `sclk`=0, then goes to SHIFT_LO.
- SHIFT_LO lasts CLK_DIV cycles with `sclk`=0. The edge leaving it sets `sclk`=1 and shifts: shift ← {shift[DSIZE-2:0], miso_s}.
- SHIFT_HI lasts CLK_DIV cycles. The leaving edge sets `sclk`=0.
  - If fewer than DSIZE bits have been taken, go to SHIFT_LO.
  - Otherwise, if `wready`=1: on that edge `wdata`←shift, `wvalid`=1, `byte_cnt`+1, and go to SHIFT_LO (next word), or to GAP if this was word FRAME_BYTES.
  - Otherwise go to HOLD.
- HOLD: `sclk`=0, `cs_n`=0, shift register preserved. The first edge that sees `wready`=1 performs the delivery described above.
- GAP: `cs_n`=1 for CLK_DIV cycles, then IDLE with `busy`=0.
- `miso_s` is `miso` sampled directly, or passed through the 2-flop synchronizer (see Configuration).
- Bit counter is 3 bits and wraps modulo DSIZE. `byte_cnt` saturates at FRAME_BYTES and clears on the next accepted `start`.
- Asserting `rst` mid-frame immediately forces all reset values. A partial word is discarded and no `wvalid` is emitted.

## Timing
- `start` is accepted at edge 0.
- Rising `sclk` edges (sample points) occur at edge 1+2·CLK_DIV+2·CLK_DIV·k for bit k.
- First `wvalid` occurs at edge 1+(2+2·DSIZE-1)·CLK_DIV, which is 69 for the defaults.
- Word period with no stall is 2·DSIZE·CLK_DIV cycles (64 for the defaults).
- A `wready` stall of N cycles delays that word and all later words by N cycles; no bits are lost.
- `frame_done` is high in the same cycle as the FRAME_BYTES-th `wvalid`.
- `cs_n` rises on the following edge and stays high for CLK_DIV cycles before a new `start` can be accepted.
- With `start` held high continuously, frames run back-to-back, separated by exactly CLK_DIV+1 cycles of `cs_n`=1 (GAP plus the IDLE cycle).

## Configuration
- `SPI_MISO_SYNC_EN` defined: `miso` passes through a 2-flop synchronizer, and the value sampled is the `miso` pin value from 2 cycles before the sample edge. CLK_DIV must be ≥3 so that data launched on the falling `sclk` edge is stable by then. `sclk`, `cs_n` and `wvalid` timing is unchanged.
- Not defined: `miso` is sampled directly and CLK_DIV ≥1 is allowed.

## Structure
- Shared package `spi_pkg` holds:
  - the state enum type `spi_rx_state_t`;
  - the default localparams (DSIZE, CLK_DIV, FRAME_BYTES);
  - a `SPI_FRAME_BITS` = DSIZE·FRAME_BYTES constant (120) shared with the output FIFO.
- Sub-module `spi_sync2` is the 2-flop synchronizer with async active-low reset to 0. It is instantiated only under `SPI_MISO_SYNC_EN`.

## Test plan
- **Reset:** assert `rst`=0 at an arbitrary time → all outputs at their reset values within the same cycle; `sclk` stays 0 with no `start`.
- **Single frame** (defaults, `wready`=1, slave drives 0xA5, 0x01..0x0E):
  - 15 `wvalid` pulses with matching `wdata`;
  - first pulse at edge 69, spacing 64 cycles;
  - `frame_done` with the 15th pulse;
  - `cs_n` high for 4 cycles afterwards.
- **Stall:** hold `wready`=0 for 10 cycles at word 3 (0x02) → `sclk` is low and `cs_n` is low throughout; 0x02 is delivered on the first edge with `wready`=1; all remaining words are correct and shifted by 10 cycles.
- **Back-to-back:** pulse `start` mid-frame → ignored; hold `start` high continuously → back-to-back frames with a 5-cycle `cs_n`-high gap, and `byte_cnt` clears to 0 at the start of the second frame.
- **Reset mid-frame:** `rst` low during word 5 → no `wvalid`, `cs_n`=1 immediately; the next `start` yields a complete 15-word frame beginning with the first word.
- **Synchronizer:** with `SPI_MISO_SYNC_EN` and CLK_DIV=3, slave changes `miso` on the falling `sclk` edge with pattern 0x5A → 0x5A is received; first `wvalid` at edge 52.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI receive path
// and the output FIFO that consumes its frames.
package spi_pkg;

  localparam int DSIZE          = 8;
  localparam int CLK_DIV        = 4;
  localparam int FRAME_BYTES    = 15;
  localparam int SPI_FRAME_BITS = DSIZE * FRAME_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } spi_rx_state_t;

endpackage

// File: rtl/spi_miso_rx_if.sv
// spi_miso_rx_if: word handshake between the SPI receiver
// (master side) and the output FIFO (slave side).
interface spi_miso_rx_if #(
  parameter int DSIZE = spi_pkg::DSIZE
);

  logic [DSIZE-1:0] wdata;
  logic             wvalid;
  logic             wready;
  logic             frame_done;

  modport master (
    output wdata,
    output wvalid,
    output frame_done,
    input  wready
  );

  modport slave (
    input  wdata,
    input  wvalid,
    input  frame_done,
    output wready
  );

endinterface

// File: rtl/spi_sync2.sv
// spi_sync2: two-flop synchronizer, async active-low reset to 0.
// Used on miso when SPI_MISO_SYNC_EN is defined.
module spi_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_miso_rx.sv
// spi_miso_rx: SPI mode-0 master receiver, fixed-length frames.
// Define SPI_MISO_SYNC_EN to put miso through spi_sync2.
module spi_miso_rx
  import spi_pkg::*;
#(
  parameter int DSIZE       = spi_pkg::DSIZE,
  parameter int CLK_DIV     = spi_pkg::CLK_DIV,
  parameter int FRAME_BYTES = spi_pkg::FRAME_BYTES,
  localparam int BCW        = $clog2(FRAME_BYTES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           miso,
  output logic           sclk,
  output logic           cs_n,
  output logic           busy,
  output logic [BCW-1:0] byte_cnt,
  spi_miso_rx_if.master  wr
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DSIZE);

  spi_rx_state_t    state;
  logic [DW-1:0]    div;
  logic [BW-1:0]    bit_cnt;
  logic [DSIZE-1:0] shift;
  logic             miso_s;
  logic             div_done;
  logic             word_full;
  logic             deliver;
  logic             last_word;
  logic [BCW-1:0]   cnt_next;

`ifdef SPI_MISO_SYNC_EN
  spi_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (miso),
    .q   (miso_s)
  );
`else
  assign miso_s = miso;
`endif

  assign div_done  = (div == DW'(CLK_DIV - 1));
  // bit_cnt wraps to 0 on the DSIZE-th shift
  assign word_full = (state == SHIFT_HI) && div_done
                   && (bit_cnt == '0);
  assign deliver   = wr.wready
                   && (word_full || (state == HOLD));
  assign last_word = (byte_cnt == BCW'(FRAME_BYTES - 1));
  assign cnt_next  = (byte_cnt == BCW'(FRAME_BYTES))
                   ? byte_cnt
                   : byte_cnt + BCW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      sclk          <= 1'b0;
      cs_n          <= 1'b1;
      busy          <= 1'b0;
      byte_cnt      <= '0;
      div           <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      wr.wdata      <= '0;
      wr.wvalid     <= 1'b0;
      wr.frame_done <= 1'b0;
    end else begin
      wr.wvalid     <= 1'b0;
      wr.frame_done <= 1'b0;
      div           <= div + DW'(1);
      unique case (state)
        IDLE: begin
          div <= '0;
          if (start) begin
            state    <= SETUP;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            byte_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        // one extra lead cycle between cs_n low and the first half-period
        SETUP: begin
          if (div == DW'(CLK_DIV)) begin
            state <= SHIFT_LO;
            div   <= '0;
          end
        end
        SHIFT_LO: begin
          if (div_done) begin
            state <= SHIFT_HI;
            div   <= '0;
            sclk  <= 1'b1;
            shift <= {shift[DSIZE-2:0], miso_s};
            bit_cnt <= (bit_cnt == BW'(DSIZE - 1))
                     ? '0
                     : bit_cnt + BW'(1);
          end
        end
        SHIFT_HI: begin
          if (div_done) begin
            sclk <= 1'b0;
            div  <= '0;
            if (bit_cnt != '0)
              state <= SHIFT_LO;
            else if (!wr.wready)
              state <= HOLD;
          end
        end
        HOLD: begin
          div <= '0;
        end
        GAP: begin
          if (div_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            div   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          div   <= '0;
        end
      endcase
      if (deliver) begin
        wr.wdata  <= shift;
        wr.wvalid <= 1'b1;
        byte_cnt  <= cnt_next;
        if (last_word) begin
          state         <= GAP;
          cs_n          <= 1'b1;
          wr.frame_done <= 1'b1;
        end else begin
          state <= SHIFT_LO;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_miso_rx.sv
// tb_spi_miso_rx: randomized frames against a timing/data model
// built from the frame rules (first word, word period, stalls, gap).
module tb_spi_miso_rx;

  localparam int D = 8;
`ifdef SPI_MISO_SYNC_EN
  localparam int C = 3;
`else
  localparam int C = 4;
`endif
  localparam int FB    = 15;
  localparam int BCW   = $clog2(FB + 1);
  localparam int FIRST = 1 + (2 * D + 1) * C;
  localparam int PER   = 2 * D * C;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           miso = 1'b0;
  logic           sclk;
  logic           cs_n;
  logic           busy;
  logic [BCW-1:0] byte_cnt;

  spi_miso_rx_if #(.DSIZE(D)) wif ();

  spi_miso_rx #(
    .DSIZE       (D),
    .CLK_DIV     (C),
    .FRAME_BYTES (FB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .miso     (miso),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .busy     (busy),
    .byte_cnt (byte_cnt),
    .wr       (wif)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [D-1:0] sbytes [FB];

  typedef struct {
    int             e;
    logic [D-1:0]   d;
    logic           fd;
    logic [BCW-1:0] bc;
  } ev_t;

  ev_t obs[$];
  int  cs_ev[$];
  int  bs_ev[$];
  int  st_s = -1000;
  int  st_n = 0;

  // slave: presents MSB while deselected, next bit after each sclk fall
  initial begin
    int   sidx;
    logic sclk_q;
    sidx   = 0;
    sclk_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cs_n !== 1'b0) sidx = 0;
      else if (sclk_q && !sclk) sidx++;
      sclk_q = sclk;
      miso = sbytes[(sidx / D) % FB][D - 1 - (sidx % D)];
    end
  end

  initial begin
    wif.wready = 1'b1;
    forever begin
      @(negedge clk);
      wif.wready = !(cyc >= st_s && cyc < st_s + st_n);
    end
  end

  initial begin
    ev_t  ev;
    logic cs_q;
    logic bs_q;
    cs_q = 1'b1;
    bs_q = 1'b0;
    forever begin
      @(negedge clk);
      if (wif.wvalid === 1'b1) begin
        ev.e  = cyc - 1;
        ev.d  = wif.wdata;
        ev.fd = wif.frame_done;
        ev.bc = byte_cnt;
        obs.push_back(ev);
      end
      if (cs_n !== cs_q) begin
        cs_ev.push_back(cyc - 1);
        cs_q = cs_n;
      end
      if (busy !== bs_q) begin
        bs_ev.push_back(cyc - 1);
        bs_q = busy;
      end
      if (cyc - 1 >= st_s && cyc - 1 < st_s + st_n) begin
        chk("stall_sclk", sclk, 0);
        chk("stall_cs_n", cs_n, 0);
      end
    end
  end

  task automatic clear_logs();
    obs.delete();
    cs_ev.delete();
    bs_ev.delete();
  endtask

  task automatic do_start(output int a, input bit hold);
    @(negedge clk);
    start = 1'b1;
    a = cyc;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("start_cs_n", cs_n, 0);
    chk("start_busy", busy, 1);
    chk("start_cnt", byte_cnt, 0);
  endtask

  task automatic check_frame(input int a, input int sw,
                             input int sn, input string nm);
    int   lim;
    int   ex;
    ev_t  ev;
    lim = a + FIRST + PER * (FB - 1) + sn + 40;
    while (obs.size() < FB && cyc < lim) @(negedge clk);
    chk({nm, "_count"}, obs.size(), FB);
    for (int w = 0; w < FB && obs.size() > 0; w++) begin
      ev = obs.pop_front();
      ex = a + FIRST + PER * w + ((w >= sw) ? sn : 0);
      chk($sformatf("%s_edge%0d", nm, w), ev.e, ex);
      chk($sformatf("%s_data%0d", nm, w), ev.d, sbytes[w]);
      chk($sformatf("%s_done%0d", nm, w), ev.fd, (w == FB - 1));
      chk($sformatf("%s_cnt%0d", nm, w), ev.bc, w + 1);
    end
  endtask

  task automatic check_tail(input int a, input int e_last,
                            input string nm);
    while (cyc < e_last + C + 4) @(negedge clk);
    chk({nm, "_cs_fall"},
        cs_ev.size() > 0 ? cs_ev.pop_front() : -1, a);
    chk({nm, "_cs_rise"},
        cs_ev.size() > 0 ? cs_ev.pop_front() : -1, e_last);
    chk({nm, "_busy_rise"},
        bs_ev.size() > 0 ? bs_ev.pop_front() : -1, a);
    chk({nm, "_busy_fall"},
        bs_ev.size() > 0 ? bs_ev.pop_front() : -1, e_last + C);
  endtask

  task automatic run_frame(input int sw, input int sn,
                           input string nm);
    int a;
    clear_logs();
    do_start(a, 1'b0);
    st_s = a + FIRST + PER * sw;
    st_n = sn;
    check_frame(a, sw, sn, nm);
    st_n = 0;
    check_tail(a, a + FIRST + PER * (FB - 1) + sn, nm);
    chk({nm, "_idle_cs_n"}, cs_n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a;
    int a2;
    int e1;
    int sw;
    int sn;

    for (int i = 0; i < FB; i++)
      sbytes[i] = (i == 0) ? 8'hA5 : D'(i);

    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_wdata", wif.wdata, 0);
    chk("rst_wvalid", wif.wvalid, 0);
    chk("rst_done", wif.frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", byte_cnt, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_sclk", sclk, 0);
    chk("idle_cs_n", cs_n, 1);

    // fixed pattern, stray start pulse mid-frame
    clear_logs();
    do_start(a, 1'b0);
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_busy", busy, 1);
    check_frame(a, FB, 0, "fix");
    check_tail(a, a + FIRST + PER * (FB - 1), "fix");

    run_frame(2, 10, "stall");

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FB; i++) sbytes[i] = D'($urandom);
      if (f == 0) sbytes[0] = 8'h5A;
      sw = $urandom_range(FB - 1, 0);
      sn = $urandom_range(20, 1);
      run_frame(sw, sn, $sformatf("rnd%0d", f));
    end

    // start held high: two frames back to back
    for (int i = 0; i < FB; i++) sbytes[i] = D'($urandom);
    clear_logs();
    do_start(a, 1'b1);
    check_frame(a, FB, 0, "b2b1");
    e1 = a + FIRST + PER * (FB - 1);
    a2 = e1 + C + 1;
    while (cyc < a2 + 1) @(negedge clk);
    start = 1'b0;
    chk("b2b_cnt_clear", byte_cnt, 0);
    chk("b2b_cs_n", cs_n, 0);
    check_tail(a, e1, "b2b1");
    check_frame(a2, FB, 0, "b2b2");
    check_tail(a2, a2 + FIRST + PER * (FB - 1), "b2b2");

    // reset while receiving the fifth word
    for (int i = 0; i < FB; i++) sbytes[i] = D'($urandom);
    clear_logs();
    do_start(a, 1'b0);
    while (cyc < a + FIRST + PER * 3 + 20) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_cs_n", cs_n, 1);
    chk("mid_rst_wvalid", wif.wvalid, 0);
    chk("mid_rst_wdata", wif.wdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", byte_cnt, 0);
    chk("mid_rst_words", obs.size(), 4);
    obs.delete();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (PER) @(negedge clk);
    chk("mid_rst_no_wvalid", obs.size(), 0);
    run_frame(FB, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
